// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and SPI mode-0 bus constants
package spi_pkg;
  typedef enum logic [1:0] {IDLE, TRANSFER, CS_HOLD, CS_INACTIVE} state_t;
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: SPI clock divider producing the half-bit tick and rise/fall edge strobes
// Ports: clk, rst (async, active high); i_en runs the divider; o_tick marks each half-bit
// boundary; o_rise/o_fall qualify the tick by the SPI clock edge it produces; o_sclk is the
// registered SPI clock, idling at CPOL.
module spi_clk_gen import spi_pkg::*; #(
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick,
  output logic o_rise,
  output logic o_fall,
  output logic o_sclk
);
  localparam int CNT_W = $clog2(CLKS_PER_HALF_BIT);
  logic [CNT_W-1:0] r_cnt;
  assign o_tick = i_en && (r_cnt == CNT_W'(CLKS_PER_HALF_BIT - 1));
  assign o_rise = o_tick && (o_sclk == CPOL);
  assign o_fall = o_tick && (o_sclk != CPOL);
  // the counter is held at 0 while disabled so every byte starts a full half period
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt  <= '0;
      o_sclk <= CPOL;
    end else begin
      r_cnt <= (o_tick || !i_en) ? '0 : r_cnt + 1'b1;
      if (o_tick) o_sclk <= ~o_sclk;
    end
endmodule

// File: rtl/spi_master_cs.sv
// spi_master_cs: SPI mode-0 master sending up to MAX_BYTES_PER_CS bytes per chip-select window
// Ports: clk_12MHz, rst (async, active high); i_tx_count/i_tx_byte/i_tx_dv load bytes while
// o_tx_ready; o_rx_byte/o_rx_dv/o_rx_count report each received byte and its index in the CS
// window; o_SPI_CLK/o_SPI_MOSI/o_SPI_CS/i_SPI_MISO form the SPI bus.
module spi_master_cs import spi_pkg::*; #(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int MAX_BYTES_PER_CS  = 2,
  parameter int CS_INACTIVE_CLKS  = 1,
  parameter int CW                = $clog2(MAX_BYTES_PER_CS + 1)
) (
  input  logic          clk_12MHz,
  input  logic          rst,
  input  logic [CW-1:0] i_tx_count,
  input  logic [7:0]    i_tx_byte,
  input  logic          i_tx_dv,
  output logic          o_tx_ready,
  output logic [7:0]    o_rx_byte,
  output logic          o_rx_dv,
  output logic [CW-1:0] o_rx_count,
  output logic          o_SPI_CLK,
  output logic          o_SPI_MOSI,
  input  logic          i_SPI_MISO,
  output logic          o_SPI_CS
);
  localparam int IW = (CS_INACTIVE_CLKS > 1) ? $clog2(CS_INACTIVE_CLKS) : 1;
  state_t        r_state;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic [2:0]    r_fall;
  logic [CW-1:0] r_left;
  logic [IW-1:0] r_inact;
  logic          w_tick;
  logic          w_rise;
  logic          w_fall;

  spi_clk_gen #(.CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)) u_clk_gen (
    .clk    (clk_12MHz),
    .rst    (rst),
    .i_en   (r_state == TRANSFER),
    .o_tick (w_tick),
    .o_rise (w_rise),
    .o_fall (w_fall),
    .o_sclk (o_SPI_CLK)
  );

  always_ff @(posedge clk_12MHz or posedge rst)
    if (rst) begin
      r_state    <= IDLE;
      r_tx       <= '0;
      r_rx       <= '0;
      r_fall     <= '0;
      r_left     <= '0;
      r_inact    <= '0;
      o_tx_ready <= 1'b0;
      o_rx_byte  <= '0;
      o_rx_dv    <= 1'b0;
      o_rx_count <= '0;
      o_SPI_MOSI <= 1'b0;
      o_SPI_CS   <= 1'b1;
    end else begin
      o_rx_dv <= 1'b0;
      case (r_state)
        IDLE:
          if (i_tx_dv && o_tx_ready) begin
            r_tx       <= i_tx_byte;
            o_SPI_MOSI <= i_tx_byte[7];
            o_SPI_CS   <= 1'b0;
            o_tx_ready <= 1'b0;
            // a count of 0 is a single-byte window; r_left holds bytes still to come
            r_left     <= (i_tx_count == '0) ? '0 : i_tx_count - 1'b1;
            o_rx_count <= '0;
            r_fall     <= '0;
            r_state    <= TRANSFER;
          end else begin
            o_tx_ready <= 1'b1;
          end
        TRANSFER:
          if (w_tick) begin
            if (w_rise) r_rx <= {r_rx[6:0], i_SPI_MISO};
            if (w_fall) begin
              r_fall <= r_fall + 1'b1;
              if (r_fall == 3'd7) begin
                o_rx_dv    <= 1'b1;
                o_rx_byte  <= r_rx;
                o_tx_ready <= (r_left != '0);
                r_state    <= CS_HOLD;
              end else begin
                r_tx       <= {r_tx[6:0], 1'b0};
                o_SPI_MOSI <= r_tx[6];
              end
            end
          end
        CS_HOLD:
          if (r_left == '0) begin
            o_SPI_CS <= 1'b1;
            r_inact  <= '0;
            r_state  <= CS_INACTIVE;
          end else if (i_tx_dv) begin
            r_tx       <= i_tx_byte;
            o_SPI_MOSI <= i_tx_byte[7];
            o_tx_ready <= 1'b0;
            r_left     <= r_left - 1'b1;
            o_rx_count <= o_rx_count + 1'b1;
            r_fall     <= '0;
            r_state    <= TRANSFER;
          end
        CS_INACTIVE:
          if (r_inact == IW'(CS_INACTIVE_CLKS - 1)) begin
            o_tx_ready <= 1'b1;
            r_state    <= IDLE;
          end else begin
            r_inact <= r_inact + 1'b1;
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_master_cs.sv
// tb_spi_master_cs: self-checking bench for spi_master_cs with table, directed and random transactions
module tb_spi_master_cs;
  logic       clk_12MHz = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] i_tx_count = '0;
  logic [7:0] i_tx_byte = '0;
  logic       i_tx_dv = 1'b0;
  logic       o_tx_ready;
  logic [7:0] o_rx_byte;
  logic       o_rx_dv;
  logic [1:0] o_rx_count;
  logic       o_SPI_CLK;
  logic       o_SPI_MOSI;
  logic       i_SPI_MISO;
  logic       o_SPI_CS;

  int checks = 0;
  int errors = 0;

  int         miso_mode = 0;
  logic [7:0] sl_b0 = '0;
  logic [7:0] sl_b1 = '0;
  int         sl_idx = 0;
  logic [2:0] sl_bit = 3'd7;

  int         rise_cnt = 0;
  int         cs_rise_cnt = 0;
  logic [15:0] mosi_w = '0;
  int         rx_n = 0;
  logic [7:0] rx_b [4];
  logic [1:0] rx_c [4];
  int         cs_run = 0;
  int         cs_gap = 0;

  typedef struct {
    int         cnt;
    logic [7:0] b0;
    logic [7:0] b1;
    int         mode;
    logic [7:0] s0;
    logic [7:0] s1;
    int         gap;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t tbl [7];

  spi_master_cs dut (
    .clk_12MHz  (clk_12MHz),
    .rst        (rst),
    .i_tx_count (i_tx_count),
    .i_tx_byte  (i_tx_byte),
    .i_tx_dv    (i_tx_dv),
    .o_tx_ready (o_tx_ready),
    .o_rx_byte  (o_rx_byte),
    .o_rx_dv    (o_rx_dv),
    .o_rx_count (o_rx_count),
    .o_SPI_CLK  (o_SPI_CLK),
    .o_SPI_MOSI (o_SPI_MOSI),
    .i_SPI_MISO (i_SPI_MISO),
    .o_SPI_CS   (o_SPI_CS)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  // mode 0: loopback, 1: tied high, 2: mode-0 slave shifting sl_b0 then sl_b1 MSB first
  assign i_SPI_MISO = (miso_mode == 0) ? o_SPI_MOSI :
                      (miso_mode == 1) ? 1'b1 :
                      (sl_idx == 0) ? sl_b0[sl_bit] : sl_b1[sl_bit];

  always @(negedge o_SPI_CS) begin
    sl_idx = 0;
    sl_bit = 3'd7;
  end

  always @(negedge o_SPI_CLK)
    if (!o_SPI_CS) begin
      if (sl_bit == 3'd0) begin
        sl_bit = 3'd7;
        sl_idx = sl_idx + 1;
      end else begin
        sl_bit = sl_bit - 3'd1;
      end
    end

  always @(posedge o_SPI_CLK) begin
    rise_cnt = rise_cnt + 1;
    mosi_w = {mosi_w[14:0], o_SPI_MOSI};
  end

  always @(posedge o_SPI_CS) cs_rise_cnt = cs_rise_cnt + 1;

  always @(negedge clk_12MHz) begin
    if (o_rx_dv) begin
      if (rx_n < 4) begin
        rx_b[rx_n] = o_rx_byte;
        rx_c[rx_n] = o_rx_count;
      end
      rx_n = rx_n + 1;
    end
    if (o_SPI_CS) cs_run = cs_run + 1;
    else begin
      if (cs_run != 0) cs_gap = cs_run;
      cs_run = 0;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear();
    rx_n = 0;
    rise_cnt = 0;
    cs_rise_cnt = 0;
    mosi_w = '0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!o_tx_ready && t < 500) begin
      @(negedge clk_12MHz);
      t++;
    end
    if (!o_tx_ready) chk("ready_timeout", 32'(o_tx_ready), 32'd1);
  endtask

  task automatic send(input int c, input logic [7:0] b);
    i_tx_count = 2'(c);
    i_tx_byte = b;
    i_tx_dv = 1'b1;
    @(negedge clk_12MHz);
    i_tx_dv = 1'b0;
  endtask

  function automatic logic [7:0] model_rx(input int mode, input logic [7:0] tx, input logic [7:0] sl);
    return (mode == 0) ? tx : (mode == 1) ? 8'hFF : sl;
  endfunction

  task automatic run_vec(input vec_t v);
    int nb;
    nb = (v.cnt == 0) ? 1 : v.cnt;
    miso_mode = v.mode;
    sl_b0 = v.s0;
    sl_b1 = v.s1;
    wait_ready();
    clear();
    send(v.cnt, v.b0);
    if (nb == 2) begin
      wait_ready();
      repeat (v.gap) @(negedge clk_12MHz);
      send(int'($urandom_range(0, 3)), v.b1);
    end
    wait_ready();
    chk("rx_n", 32'(rx_n), 32'(nb));
    chk("rx_byte0", 32'(rx_b[0]), 32'(v.e0));
    chk("rx_count0", 32'(rx_c[0]), 32'd0);
    if (nb == 2) begin
      chk("rx_byte1", 32'(rx_b[1]), 32'(v.e1));
      chk("rx_count1", 32'(rx_c[1]), 32'd1);
      chk("mosi16", 32'(mosi_w), 32'({v.b0, v.b1}));
    end else begin
      chk("mosi8", 32'(mosi_w[7:0]), 32'(v.b0));
    end
    chk("rises", 32'(rise_cnt), 32'(8 * nb));
    chk("cs_windows", 32'(cs_rise_cnt), 32'd1);
  endtask

  initial begin
    int k_rise, k_dv, k_cs, k_rdy, t;
    vec_t v;
    tbl[0] = '{1, 8'hA5, 8'h00, 0, 8'h00, 8'h00, 0,  8'hA5, 8'h00};
    tbl[1] = '{2, 8'h81, 8'h5A, 0, 8'h00, 8'h00, 10, 8'h81, 8'h5A};
    tbl[2] = '{0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0,  8'hFF, 8'h00};
    tbl[3] = '{2, 8'h3C, 8'hC3, 1, 8'h00, 8'h00, 3,  8'hFF, 8'hFF};
    tbl[4] = '{2, 8'h12, 8'h34, 2, 8'hC5, 8'h3A, 2,  8'hC5, 8'h3A};
    tbl[5] = '{1, 8'hF0, 8'h00, 2, 8'h69, 8'h00, 0,  8'h69, 8'h00};
    tbl[6] = '{2, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 0,  8'h00, 8'hFF};

    repeat (2) @(negedge clk_12MHz);
    chk("rst_cs", 32'(o_SPI_CS), 32'd1);
    chk("rst_sclk", 32'(o_SPI_CLK), 32'd0);
    chk("rst_mosi", 32'(o_SPI_MOSI), 32'd0);
    chk("rst_ready", 32'(o_tx_ready), 32'd0);
    chk("rst_rx_dv", 32'(o_rx_dv), 32'd0);
    chk("rst_rx_byte", 32'(o_rx_byte), 32'd0);
    chk("rst_rx_count", 32'(o_rx_count), 32'd0);
    rst = 1'b0;
    @(negedge clk_12MHz);
    chk("ready_after_rst", 32'(o_tx_ready), 32'd1);

    // single byte 0xA5 cycle timing, measured from the accepting cycle N
    miso_mode = 0;
    clear();
    send(1, 8'hA5);
    chk("n1_cs", 32'(o_SPI_CS), 32'd0);
    chk("n1_mosi", 32'(o_SPI_MOSI), 32'd1);
    chk("n1_ready", 32'(o_tx_ready), 32'd0);
    chk("n1_rx_count", 32'(o_rx_count), 32'd0);
    k_rise = 0; k_dv = 0; k_cs = 0; k_rdy = 0;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk_12MHz);
      if (o_SPI_CLK && k_rise == 0) k_rise = k;
      if (o_rx_dv && k_dv == 0) k_dv = k;
      if (o_SPI_CS && k_cs == 0) k_cs = k;
      if (o_tx_ready && k_rdy == 0) k_rdy = k;
    end
    chk("first_rise_cycle", 32'(k_rise), 32'd3);
    chk("rx_dv_cycle", 32'(k_dv), 32'd33);
    chk("cs_high_cycle", 32'(k_cs), 32'd34);
    chk("ready_cycle", 32'(k_rdy), 32'd35);
    chk("timing_rx_byte", 32'(rx_b[0]), 32'hA5);
    chk("timing_mosi", 32'(mosi_w[7:0]), 32'hA5);
    chk("timing_rises", 32'(rise_cnt), 32'd8);
    chk("timing_rx_n", 32'(rx_n), 32'd1);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // strobe mid-byte must be ignored
    miso_mode = 0;
    wait_ready();
    clear();
    send(1, 8'h96);
    repeat (10) @(negedge clk_12MHz);
    send(2, 8'h3C);
    wait_ready();
    chk("ign_rx_n", 32'(rx_n), 32'd1);
    chk("ign_rx_byte", 32'(rx_b[0]), 32'h96);
    chk("ign_mosi", 32'(mosi_w[7:0]), 32'h96);
    chk("ign_rises", 32'(rise_cnt), 32'd8);

    // reset after the 4th rising edge aborts the byte
    wait_ready();
    clear();
    send(1, 8'hA5);
    t = 0;
    while (rise_cnt < 4 && t < 200) begin
      @(negedge clk_12MHz);
      t++;
    end
    chk("abort_reach_4", 32'(rise_cnt), 32'd4);
    rst = 1'b1;
    #1;
    chk("abort_cs", 32'(o_SPI_CS), 32'd1);
    chk("abort_sclk", 32'(o_SPI_CLK), 32'd0);
    chk("abort_ready", 32'(o_tx_ready), 32'd0);
    repeat (3) @(negedge clk_12MHz);
    chk("abort_no_rx", 32'(rx_n), 32'd0);
    rst = 1'b0;
    @(negedge clk_12MHz);
    chk("abort_ready_after", 32'(o_tx_ready), 32'd1);
    run_vec('{1, 8'h0F, 8'h00, 0, 8'h00, 8'h00, 0, 8'h0F, 8'h00});

    // back-to-back single-byte transactions
    miso_mode = 0;
    wait_ready();
    clear();
    send(1, 8'h11);
    wait_ready();
    send(1, 8'h22);
    wait_ready();
    chk("b2b_rx_n", 32'(rx_n), 32'd2);
    chk("b2b_byte0", 32'(rx_b[0]), 32'h11);
    chk("b2b_count0", 32'(rx_c[0]), 32'd0);
    chk("b2b_byte1", 32'(rx_b[1]), 32'h22);
    chk("b2b_count1", 32'(rx_c[1]), 32'd0);
    chk("b2b_cs_gap_min", 32'(cs_gap >= 1), 32'd1);
    chk("b2b_cs_windows", 32'(cs_rise_cnt), 32'd2);

    for (int r = 0; r < 40; r++) begin
      v.cnt = int'($urandom_range(0, 2));
      v.b0 = 8'($urandom);
      v.b1 = 8'($urandom);
      v.mode = int'($urandom_range(0, 2));
      v.s0 = 8'($urandom);
      v.s1 = 8'($urandom);
      v.gap = int'($urandom_range(0, 6));
      v.e0 = model_rx(v.mode, v.b0, v.s0);
      v.e1 = model_rx(v.mode, v.b1, v.s1);
      run_vec(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
